sprite_palette_bank: RTL and testbench

Multi-bank, runtime-writable sprite palette. Maps a pixel colour index to a 4:4:4 RGB value for the VGA pixel path, with a registered two-stage pipeline. Adds a transparency flag and frame-synchronous colour cycling (palette animation, e.g. water or wing flicker). Sits between the per-sprite ROM index fetch and the compositor/colour mapper; the CPU or game FSM rewrites entries through the write port.

---
 rtl/sprite_palette_bank_pkg.sv | 60 ++++++
 rtl/sprite_palette_bank_if.sv | 48 ++++
 rtl/sprite_palette_bank_cycle_ctrl.sv | 54 +++++
 rtl/sprite_palette_bank.sv | 193 +++++++++++++++++++
 tb/tb_sprite_palette_bank.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/sprite_palette_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_palette_pkg
//  Description : Shared types, the reset-time default colour table and the
//                helper functions used by the sprite palette bank.
//                The default table is held at 4 bits per channel. The bank
//                widens or narrows each entry to its own COLOR_W.
//  Revision    : 1.0  initial release
// ============================================================================
package sprite_palette_pkg;

  localparam int c_def_color_w = 4;
  localparam int c_def_entries = 16;

  typedef struct packed {
    logic [c_def_color_w-1:0] r;
    logic [c_def_color_w-1:0] g;
    logic [c_def_color_w-1:0] b;
  } rgb_t;

  // Entry loaded into every bank on reset. Entries beyond index 15 only
  // exist for INDEX_W > 4 and take the fill colour.
  localparam rgb_t c_fill_rgb = rgb_t'(12'hAEA);

  localparam rgb_t c_default_table [c_def_entries] = '{
    rgb_t'(12'h000), rgb_t'(12'hAEA), rgb_t'(12'hFFF), rgb_t'(12'hF76),
    rgb_t'(12'h050), rgb_t'(12'h050), rgb_t'(12'hAEA), rgb_t'(12'hAEA),
    rgb_t'(12'hAEA), rgb_t'(12'hAEA), rgb_t'(12'hAEA), rgb_t'(12'hAEA),
    rgb_t'(12'hAEA), rgb_t'(12'hAEA), rgb_t'(12'hAEA), rgb_t'(12'hAEA)
  };

  function automatic rgb_t default_entry(input int unsigned idx);
    if (idx < c_def_entries) return c_default_table[idx[3:0]];
    return c_fill_rgb;
  endfunction

  // Rotates indices inside [lo, hi] by offset. The caller keeps
  // offset < span, so one conditional subtract replaces a modulo.
  function automatic int unsigned cycle_map(input int unsigned index,
                                            input int unsigned offset,
                                            input int unsigned lo,
                                            input int unsigned hi);
    int unsigned span;
    int unsigned t;
    span = hi - lo + 1;
    if (index >= lo && index <= hi) begin
      t = index - lo + offset;
      if (t >= span) t = t - span;
      return lo + t;
    end
    return index;
  endfunction

  // Width of a field able to hold 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_palette_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_palette_bank_if
//  Description : Lookup, write, cycling-control and result signals of the
//                sprite palette bank.
//                master : pixel path / CPU side (drives requests)
//                slave  : palette bank (drives results)
//  Signals     : rd_valid/rd_bank/rd_index          lookup request
//                wr_en/wr_bank/wr_index/wr_rgb      entry write
//                frame_start/cycle_en               colour cycling control
//                out_valid/red/green/blue/transparent  lookup result
//  Revision    : 1.0  initial release
// ============================================================================
interface sprite_palette_bank_if #(
  parameter int INDEX_W = 4,
  parameter int COLOR_W = 4,
  parameter int BANK_W  = 2
);
  logic                 rd_valid;
  logic [BANK_W-1:0]    rd_bank;
  logic [INDEX_W-1:0]   rd_index;
  logic                 wr_en;
  logic [BANK_W-1:0]    wr_bank;
  logic [INDEX_W-1:0]   wr_index;
  logic [3*COLOR_W-1:0] wr_rgb;
  logic                 frame_start;
  logic                 cycle_en;
  logic                 out_valid;
  logic [COLOR_W-1:0]   red;
  logic [COLOR_W-1:0]   green;
  logic [COLOR_W-1:0]   blue;
  logic                 transparent;

  modport master (
    output rd_valid, rd_bank, rd_index,
    output wr_en, wr_bank, wr_index, wr_rgb,
    output frame_start, cycle_en,
    input  out_valid, red, green, blue, transparent
  );

  modport slave (
    input  rd_valid, rd_bank, rd_index,
    input  wr_en, wr_bank, wr_index, wr_rgb,
    input  frame_start, cycle_en,
    output out_valid, red, green, blue, transparent
  );
endinterface
`default_nettype wire

// File: rtl/sprite_palette_bank_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : palette_cycle_ctrl
//  Description : Frame-synchronous colour-cycling timer. Counts frame_start
//                pulses while cycle_en is high; every CYCLE_PERIOD pulses
//                the rotation offset steps by one, wrapping at SPAN.
//  Ports       : Clk, Reset (async, active-high)
//                frame_start  in   one-cycle pulse per frame
//                cycle_en     in   enable cycling (counter/offset hold if 0)
//                offset       out  current rotation offset, 0..SPAN-1
//  Revision    : 1.0  initial release
// ============================================================================
module palette_cycle_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int SPAN         = 2,
  parameter int CYCLE_PERIOD = 8,
  parameter int OFF_W        = 1
) (
  input  wire              Clk,
  input  wire              Reset,
  input  wire              frame_start,
  input  wire              cycle_en,
  output logic [OFF_W-1:0] offset
);

  localparam int c_cnt_w = clog2_min1(CYCLE_PERIOD);

  logic [c_cnt_w-1:0] r_cnt;
  logic [OFF_W-1:0]   r_offset;
  logic               w_step;

  assign w_step = frame_start && cycle_en;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt    <= '0;
      r_offset <= '0;
    end else if (w_step) begin
      if (r_cnt == c_cnt_w'(CYCLE_PERIOD - 1)) begin
        r_cnt <= '0;
        // SPAN = 1 pins the offset at zero, making cycling a no-op.
        if (r_offset == OFF_W'(SPAN - 1)) r_offset <= '0;
        else                              r_offset <= r_offset + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign offset = r_offset;

endmodule
`default_nettype wire

// File: rtl/sprite_palette_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_palette_bank
//  Description : Multi-bank, runtime-writable sprite palette. Maps a colour
//                index to {R,G,B}, with a two-stage lookup pipeline,
//                a transparency flag and frame-synchronous colour cycling.
//  Ports       : Clk          system clock
//                Reset        asynchronous active-high reset
//                bus (slave)  lookup request, entry write, cycling control
//                             and lookup result (sprite_palette_bank_if)
//  Revision    : 1.0  initial release
// ============================================================================
module sprite_palette_bank
  import sprite_palette_pkg::*;
#(
  parameter int INDEX_W           = 4,
  parameter int COLOR_W           = 4,
  parameter int NUM_BANKS         = 4,
  parameter int TRANSPARENT_INDEX = 1,
  parameter int CYCLE_LO          = 4,
  parameter int CYCLE_HI          = 5,
  parameter int CYCLE_PERIOD      = 8
) (
  input wire                   Clk,
  input wire                   Reset,
  sprite_palette_bank_if.slave bus
);

  localparam int c_num_entries = 2 ** INDEX_W;
  localparam int c_bank_w      = clog2_min1(NUM_BANKS);
  localparam int c_rgb_w       = 3 * COLOR_W;
  localparam int c_span        = CYCLE_HI - CYCLE_LO + 1;
  localparam int c_off_w       = clog2_min1(c_span);
  localparam int c_reps        = (COLOR_W + c_def_color_w - 1) / c_def_color_w;

  // --------------------------------------------------------------------------
  // Parameter sanity
  // --------------------------------------------------------------------------
  if (CYCLE_LO < 0 || CYCLE_LO > CYCLE_HI || CYCLE_HI >= c_num_entries) begin : g_chk_cycle_range
    $error("sprite_palette_bank: need 0 <= CYCLE_LO <= CYCLE_HI < NUM_ENTRIES");
  end
  if (TRANSPARENT_INDEX < 0 || TRANSPARENT_INDEX >= c_num_entries) begin : g_chk_transparent
    $error("sprite_palette_bank: TRANSPARENT_INDEX must be < NUM_ENTRIES");
  end
  if (CYCLE_PERIOD < 1) begin : g_chk_period
    $error("sprite_palette_bank: CYCLE_PERIOD must be >= 1");
  end

  // Replicate a 4-bit default nibble MSB-first, then keep the top COLOR_W
  // bits, so narrower widths truncate and wider ones repeat the pattern.
  function automatic logic [COLOR_W-1:0] expand_chan(input logic [c_def_color_w-1:0] n);
    logic [c_def_color_w*c_reps-1:0] rep;
    rep = {c_reps{n}};
    return rep[c_def_color_w*c_reps-1 -: COLOR_W];
  endfunction

  function automatic logic [c_rgb_w-1:0] expand_rgb(input rgb_t c);
    return {expand_chan(c.r), expand_chan(c.g), expand_chan(c.b)};
  endfunction

  // --------------------------------------------------------------------------
  // Colour-cycling timer
  // --------------------------------------------------------------------------
  logic [c_off_w-1:0] w_offset;

  palette_cycle_ctrl #(
    .SPAN         (c_span),
    .CYCLE_PERIOD (CYCLE_PERIOD),
    .OFF_W        (c_off_w)
  ) u_cycle (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (bus.frame_start),
    .cycle_en    (bus.cycle_en),
    .offset      (w_offset)
  );

  // --------------------------------------------------------------------------
  // Write path. A write is staged one cycle before it reaches the table.
  // The table is read one cycle after a lookup is requested, so staging the
  // write makes a same-cycle lookup see the old entry and the following
  // lookup see the new one, without a second read port.
  // --------------------------------------------------------------------------
  logic                r_wb_valid;
  logic [c_bank_w-1:0] r_wb_bank;
  logic [INDEX_W-1:0]  r_wb_index;
  logic [c_rgb_w-1:0]  r_wb_rgb;
  logic                w_wr_ok;

  assign w_wr_ok = bus.wr_en && (int'(bus.wr_bank) < NUM_BANKS);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_wb_valid <= 1'b0;
      r_wb_bank  <= '0;
      r_wb_index <= '0;
      r_wb_rgb   <= '0;
    end else begin
      r_wb_valid <= w_wr_ok;
      if (w_wr_ok) begin
        r_wb_bank  <= bus.wr_bank;
        r_wb_index <= bus.wr_index;
        r_wb_rgb   <= bus.wr_rgb;
      end
    end
  end

  // Flop-based storage so every bank can be reloaded by reset.
  logic [c_rgb_w-1:0] r_mem [NUM_BANKS][c_num_entries];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int unsigned e = 0; e < c_num_entries; e++) begin
          r_mem[b][e] <= expand_rgb(default_entry(e));
        end
      end
    end else if (r_wb_valid) begin
      r_mem[r_wb_bank][r_wb_index] <= r_wb_rgb;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: request, effective (cycled) index, transparency from raw index
  // --------------------------------------------------------------------------
  logic [INDEX_W-1:0]  w_eff_index;
  logic                w_rd_oob;
  logic                w_rd_transp;

  logic                r_s1_valid;
  logic [c_bank_w-1:0] r_s1_bank;
  logic [INDEX_W-1:0]  r_s1_index;
  logic                r_s1_transp;
  logic                r_s1_oob;

  assign w_eff_index = INDEX_W'(cycle_map(32'(bus.rd_index), 32'(w_offset),
                                          32'(CYCLE_LO), 32'(CYCLE_HI)));
  assign w_rd_oob    = int'(bus.rd_bank) >= NUM_BANKS;
  assign w_rd_transp = (bus.rd_index == INDEX_W'(TRANSPARENT_INDEX)) || w_rd_oob;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_bank   <= '0;
      r_s1_index  <= '0;
      r_s1_transp <= 1'b0;
      r_s1_oob    <= 1'b0;
    end else begin
      r_s1_valid <= bus.rd_valid;
      if (bus.rd_valid) begin
        r_s1_bank   <= bus.rd_bank;
        r_s1_index  <= w_eff_index;
        r_s1_transp <= w_rd_transp;
        r_s1_oob    <= w_rd_oob;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: table read; results hold while out_valid is low
  // --------------------------------------------------------------------------
  logic [c_rgb_w-1:0] w_tbl_rgb;
  logic               r_out_valid;
  logic [c_rgb_w-1:0] r_out_rgb;
  logic               r_out_transp;

  always_comb begin
    w_tbl_rgb = '0;
    if (!r_s1_oob) w_tbl_rgb = r_mem[r_s1_bank][r_s1_index];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out_valid  <= 1'b0;
      r_out_rgb    <= '0;
      r_out_transp <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_rgb    <= w_tbl_rgb;
        r_out_transp <= r_s1_transp;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.red         = r_out_rgb[c_rgb_w-1 -: COLOR_W];
  assign bus.green       = r_out_rgb[2*COLOR_W-1 -: COLOR_W];
  assign bus.blue        = r_out_rgb[COLOR_W-1:0];
  assign bus.transparent = r_out_transp;

endmodule
`default_nettype wire

// File: tb/tb_sprite_palette_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_palette_bank
//  Description : Directed self-checking bench for sprite_palette_bank with
//                three banks (bank 3 out of range), 4-bit channels,
//                cycling range 4..5 and an 8-frame cycling period.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_palette_bank;

  logic Clk = 1'b0;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 Clk = ~Clk;

  sprite_palette_bank_if #(.INDEX_W(4), .COLOR_W(4), .BANK_W(2)) bus ();

  sprite_palette_bank #(
    .INDEX_W           (4),
    .COLOR_W           (4),
    .NUM_BANKS         (3),
    .TRANSPARENT_INDEX (1),
    .CYCLE_LO          (4),
    .CYCLE_HI          (5),
    .CYCLE_PERIOD      (8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [11:0] rgb, input logic t);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'(rgb));
    check({tag, ".transp"}, 32'(bus.transparent), 32'(t));
  endtask

  task automatic req(input logic v, input logic [1:0] b, input logic [3:0] i);
    bus.rd_valid = v;
    bus.rd_bank  = b;
    bus.rd_index = i;
  endtask

  task automatic wr(input logic en, input logic [1:0] b, input logic [3:0] i, input logic [11:0] rgb);
    bus.wr_en    = en;
    bus.wr_bank  = b;
    bus.wr_index = i;
    bus.wr_rgb   = rgb;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      tick();
    end
  endtask

  // Single isolated lookup, result checked after the 2-cycle latency.
  task automatic lookup1(input string tag, input logic [1:0] b, input logic [3:0] i,
                         input logic [11:0] rgb, input logic t);
    req(1'b1, b, i);
    tick();
    req(1'b0, 2'd0, 4'd0);
    tick();
    check_out(tag, 1'b1, rgb, t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1);
  end

  initial begin
    req(1'b0, 2'd0, 4'd0);
    wr(1'b0, 2'd0, 4'd0, 12'h000);
    bus.frame_start = 1'b0;
    bus.cycle_en    = 1'b0;
    Reset = 1'b1;
    tick();
    tick();
    check_out("reset", 1'b0, 12'h000, 1'b0);
    Reset = 1'b0;
    tick();

    // Back-to-back lookups, bank 0 indices 0..3
    req(1'b1, 2'd0, 4'd0);
    tick();
    check("lat1.valid", 32'(bus.out_valid), 32'd0);
    req(1'b1, 2'd0, 4'd1);
    tick();
    check_out("b0i0", 1'b1, 12'h000, 1'b0);
    req(1'b1, 2'd0, 4'd2);
    tick();
    check_out("b0i1", 1'b1, 12'hAEA, 1'b1);
    req(1'b1, 2'd0, 4'd3);
    tick();
    check_out("b0i2", 1'b1, 12'hFFF, 1'b0);
    req(1'b0, 2'd0, 4'd0);
    tick();
    check_out("b0i3", 1'b1, 12'hF76, 1'b0);
    tick();
    check_out("hold", 1'b0, 12'hF76, 1'b0);

    // Write with a same-cycle lookup of the same entry
    wr(1'b1, 2'd2, 4'd3, 12'h123);
    req(1'b1, 2'd2, 4'd3);
    tick();
    wr(1'b0, 2'd0, 4'd0, 12'h000);
    req(1'b1, 2'd2, 4'd3);
    tick();
    check_out("wr.same", 1'b1, 12'hF76, 1'b0);
    req(1'b1, 2'd0, 4'd3);
    tick();
    check_out("wr.next", 1'b1, 12'h123, 1'b0);
    req(1'b0, 2'd0, 4'd0);
    tick();
    check_out("wr.b0", 1'b1, 12'hF76, 1'b0);

    // Colour cycling
    wr(1'b1, 2'd1, 4'd4, 12'hF00);
    tick();
    wr(1'b0, 2'd0, 4'd0, 12'h000);
    lookup1("cyc.wr", 2'd1, 4'd4, 12'hF00, 1'b0);
    bus.cycle_en = 1'b1;
    pulses(7);
    lookup1("cyc.p7", 2'd1, 4'd4, 12'hF00, 1'b0);
    pulses(1);
    lookup1("cyc.p8.i5", 2'd1, 4'd5, 12'hF00, 1'b0);
    lookup1("cyc.p8.i4", 2'd1, 4'd4, 12'h050, 1'b0);
    pulses(8);
    lookup1("cyc.wrap", 2'd1, 4'd4, 12'hF00, 1'b0);

    // Disabled cycling holds counter and offset
    pulses(3);
    bus.cycle_en = 1'b0;
    pulses(20);
    lookup1("dis.off", 2'd1, 4'd4, 12'hF00, 1'b0);
    bus.cycle_en = 1'b1;
    pulses(4);
    lookup1("dis.cnt", 2'd1, 4'd4, 12'hF00, 1'b0);
    // Lookup coincident with the advancing pulse uses the old offset
    bus.frame_start = 1'b1;
    req(1'b1, 2'd1, 4'd4);
    tick();
    bus.frame_start = 1'b0;
    req(1'b1, 2'd1, 4'd4);
    tick();
    check_out("coinc.old", 1'b1, 12'hF00, 1'b0);
    req(1'b0, 2'd0, 4'd0);
    tick();
    check_out("coinc.new", 1'b1, 12'h050, 1'b0);
    bus.cycle_en = 1'b0;
    lookup1("dis.read", 2'd1, 4'd5, 12'hF00, 1'b0);

    // Out-of-range bank
    lookup1("oob.rd", 2'd3, 4'd2, 12'h000, 1'b1);
    wr(1'b1, 2'd3, 4'd2, 12'hABC);
    tick();
    wr(1'b0, 2'd0, 4'd0, 12'h000);
    lookup1("oob.b0", 2'd0, 4'd2, 12'hFFF, 1'b0);
    lookup1("oob.b1", 2'd1, 4'd2, 12'hFFF, 1'b0);
    lookup1("oob.b2", 2'd2, 4'd2, 12'hFFF, 1'b0);

    // Reset with lookups in flight
    req(1'b1, 2'd2, 4'd3);
    tick();
    req(1'b1, 2'd2, 4'd3);
    tick();
    check_out("rst.pre", 1'b1, 12'h123, 1'b0);
    req(1'b1, 2'd0, 4'd2);
    #2;
    Reset = 1'b1;
    #1;
    check_out("rst.async", 1'b0, 12'h000, 1'b0);
    req(1'b0, 2'd0, 4'd0);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    check_out("rst.after", 1'b0, 12'h000, 1'b0);
    lookup1("rst.table", 2'd2, 4'd3, 12'hF76, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
